// File: rtl/srsc_recover_out.sv
// Scene-radiance recovery J = A +/- |I-A|/T with saturation, FWFT output FIFO, frame tagging; ROUND_BEHAVIOUR_EN selects round-half-up.
// Latency: i_valid to o_valid is 2 clk (stage A register + FIFO write) when the FIFO is empty.
// Backpressure: o_ready stalls the FIFO only; i_ready is advisory and a write into a full FIFO is dropped and sets sticky o_overflow.
module srsc_recover_out #(
  parameter int FRAC_BITS  = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [15:0] i_mult_r,
  input  logic [15:0] i_mult_g,
  input  logic [15:0] i_mult_b,
  input  logic        i_sub_r,
  input  logic        i_sub_g,
  input  logic        i_sub_b,
  input  logic [7:0]  i_a_r,
  input  logic [7:0]  i_a_g,
  input  logic [7:0]  i_a_b,
  output logic [7:0]  o_j_r,
  output logic [7:0]  o_j_g,
  output logic [7:0]  o_j_b,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  function automatic logic [7:0] recover(input logic [15:0] mult, input logic sub,
                                         input logic [7:0] a);
    logic [16:0]        mag;
    logic signed [17:0] sum;
    logic [7:0]         res;
`ifdef ROUND_BEHAVIOUR_EN
    mag = ({1'b0, mult} + (17'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
`else
    mag = {1'b0, mult} >> FRAC_BITS;
`endif
    if (sub) sum = $signed({10'b0, a}) - $signed({1'b0, mag});
    else     sum = $signed({10'b0, a}) + $signed({1'b0, mag});
    if (sum < 0)                     res = 8'd0;
    else if (sum > 18'sd255)         res = 8'd255;
    else                             res = sum[7:0];
    return res;
  endfunction

  logic          a_vld;
  pix_t          a_pix;
  pix_t          mem [FIFO_DEPTH];
  pix_t          rd_pix;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          full, empty, push, pop;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld <= 1'b0;
      a_pix <= '0;
    end else begin
      a_vld <= i_valid;
      a_pix <= '{r: recover(i_mult_r, i_sub_r, i_a_r),
                 g: recover(i_mult_g, i_sub_g, i_a_g),
                 b: recover(i_mult_b, i_sub_b, i_a_b)};
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = o_valid && o_ready;
  // A full FIFO still accepts when the same cycle pops.
  assign push    = a_vld && (!full || pop);
  assign i_ready = (count <= PW'(FIFO_DEPTH - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (a_vld && full && !pop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= a_pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pop) begin
      if (x == XW'(IMG_WIDTH - 1)) begin
        x <= '0;
        y <= (y == YW'(IMG_HEIGHT - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign rd_pix  = mem[rd_ptr[AW-1:0]];
  assign o_valid = !empty;
  assign o_j_r   = o_valid ? rd_pix.r : 8'd0;
  assign o_j_g   = o_valid ? rd_pix.g : 8'd0;
  assign o_j_b   = o_valid ? rd_pix.b : 8'd0;
  assign o_sof   = o_valid && (x == '0) && (y == '0);
  assign o_eol   = o_valid && (x == XW'(IMG_WIDTH - 1));
  assign o_eof   = o_eol && (y == YW'(IMG_HEIGHT - 1));

endmodule
